// File: rtl/usb_tx_pkg.sv
// ============================================================================
// Module      : usb_tx_pkg
// Description : Shared types and constants for the USB packet transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_PID     = 3'd2,
        ST_DATA    = 3'd3,
        ST_CRC     = 3'd4,
        ST_EOP_SE0 = 3'd5,
        ST_EOP_J   = 3'd6
    } tx_state_t;

    localparam logic [7:0]  SYNC_BYTE    = 8'h80;
    localparam logic [3:0]  PID_DATA0    = 4'h3;
    localparam logic [3:0]  PID_DATA1    = 4'hB;
    localparam logic [3:0]  PID_ACK      = 4'h2;
    localparam logic [3:0]  PID_NAK      = 4'hA;
    localparam logic [15:0] CRC16_POLY_R = 16'hA001;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam int          STUFF_LIMIT  = 6;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_tx_crc16.sv
// ============================================================================
// Module      : usb_tx_crc16
// Description : Bit-serial reflected CRC16 (USB data CRC) register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_tx_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;
    logic [15:0] w_crc_next;

    assign w_crc_next = (r_crc[0] ^ i_bit) ? ((r_crc >> 1) ^ CRC16_POLY_R)
                                           : (r_crc >> 1);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= w_crc_next;
        end
    end

    assign o_crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/usb_tx_packetizer.sv
// ============================================================================
// Module      : usb_tx_packetizer
// Description : Full-speed USB packet serialiser with bit stuffing and NRZI.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_tx_packetizer
    import usb_tx_pkg::*;
#(
    parameter int MAX_BYTES    = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int LENW         = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_start,
    input  logic [3:0]             tx_pid,
    input  logic [LENW-1:0]        tx_len,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   d_plus,
    output logic                   d_minus
);

    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int BIDXW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [TW-1:0]   c_last_tick = TW'(CLKS_PER_BIT - 1);
    localparam logic [LENW-1:0] c_max_len   = LENW'(MAX_BYTES);

    tx_state_t              r_state, w_state;
    logic [TW-1:0]          r_timer, w_timer;
    logic [3:0]             r_bit_idx, w_bit_idx;
    logic [BIDXW-1:0]       r_byte_idx, w_byte_idx;
    logic [2:0]             r_ones, w_ones;
    logic                   r_dp, r_dm, w_dp, w_dm;
    logic [3:0]             r_pid;
    logic                   r_is_data;
    logic [LENW-1:0]        r_len;
    logic [8*MAX_BYTES-1:0] r_data;

    logic [15:0] w_crc;
    logic        w_crc_clear, w_crc_en, w_crc_bit;
    logic        w_accept, w_tick, w_stuff_now, w_last_byte;
    logic        w_send, w_bit;
    logic [7:0]  w_pid_byte;

    usb_tx_crc16 u_crc (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_crc_clear),
        .i_en    (w_crc_en),
        .i_bit   (w_crc_bit),
        .o_crc   (w_crc)
    );

    assign w_accept    = tx_start && (r_state == ST_IDLE);
    assign w_tick      = (r_state != ST_IDLE) && (r_timer == c_last_tick);
    assign w_pid_byte  = {~r_pid, r_pid};
    assign w_last_byte = ((LENW'(r_byte_idx) + LENW'(1)) == r_len);
    // The ones counter already includes the bit now on the line, so a stuff
    // bit is due at the boundary following the sixth consecutive one.
    assign w_stuff_now = ((r_state == ST_SYNC) || (r_state == ST_PID) ||
                          (r_state == ST_DATA) || (r_state == ST_CRC)) &&
                         (r_ones == 3'(STUFF_LIMIT));

    always_comb begin
        w_state     = r_state;
        w_timer     = r_timer;
        w_bit_idx   = r_bit_idx;
        w_byte_idx  = r_byte_idx;
        w_ones      = r_ones;
        w_dp        = r_dp;
        w_dm        = r_dm;
        w_send      = 1'b0;
        w_bit       = 1'b0;
        w_crc_clear = 1'b0;
        w_crc_en    = 1'b0;
        w_crc_bit   = 1'b0;

        if (r_state == ST_IDLE) begin
            if (w_accept) begin
                w_state     = ST_SYNC;
                w_timer     = '0;
                w_bit_idx   = '0;
                w_byte_idx  = '0;
                w_ones      = '0;
                w_crc_clear = 1'b1;
                w_send      = 1'b1;
            end
        end else begin
            w_timer = w_tick ? '0 : r_timer + 1'b1;
            if (w_tick) begin
                if (w_stuff_now) begin
                    w_send = 1'b1;
                end else begin
                    case (r_state)
                        ST_SYNC: begin
                            w_send = 1'b1;
                            if (r_bit_idx == 4'd7) begin
                                w_state   = ST_PID;
                                w_bit_idx = '0;
                            end else begin
                                w_bit_idx = r_bit_idx + 1'b1;
                            end
                        end
                        ST_PID: begin
                            if (r_bit_idx == 4'd7) begin
                                w_bit_idx  = '0;
                                w_byte_idx = '0;
                                w_send     = r_is_data;
                                if (!r_is_data) begin
                                    w_state = ST_EOP_SE0;
                                end else if (r_len == '0) begin
                                    w_state = ST_CRC;
                                end else begin
                                    w_state = ST_DATA;
                                end
                            end else begin
                                w_send    = 1'b1;
                                w_bit_idx = r_bit_idx + 1'b1;
                            end
                        end
                        ST_DATA: begin
                            w_send = 1'b1;
                            if (r_bit_idx == 4'd7) begin
                                w_bit_idx = '0;
                                if (w_last_byte) begin
                                    w_state = ST_CRC;
                                end else begin
                                    w_byte_idx = r_byte_idx + 1'b1;
                                end
                            end else begin
                                w_bit_idx = r_bit_idx + 1'b1;
                            end
                        end
                        ST_CRC: begin
                            if (r_bit_idx == 4'd15) begin
                                w_state   = ST_EOP_SE0;
                                w_bit_idx = '0;
                            end else begin
                                w_send    = 1'b1;
                                w_bit_idx = r_bit_idx + 1'b1;
                            end
                        end
                        ST_EOP_SE0: begin
                            if (r_bit_idx == 4'd1) begin
                                w_state = ST_EOP_J;
                            end else begin
                                w_bit_idx = r_bit_idx + 1'b1;
                            end
                        end
                        default: begin
                            w_state = ST_IDLE;
                        end
                    endcase
                end
            end
        end

        // Pick the field bit for the new position; a stuff bit stays 0.
        if (w_send && !w_stuff_now) begin
            case (w_state)
                ST_SYNC: w_bit = SYNC_BYTE[w_bit_idx[2:0]];
                ST_PID:  w_bit = w_pid_byte[w_bit_idx[2:0]];
                ST_DATA: begin
                    w_bit     = r_data[{w_byte_idx, w_bit_idx[2:0]}];
                    w_crc_en  = 1'b1;
                    w_crc_bit = w_bit;
                end
                ST_CRC:  w_bit = ~w_crc[w_bit_idx];
                default: w_bit = 1'b0;
            endcase
        end

        if (w_send) begin
            w_ones = w_bit ? r_ones + 1'b1 : '0;
            if (!w_bit) begin
                w_dp = r_dm;
                w_dm = r_dp;
            end
        end else if (w_state == ST_EOP_SE0) begin
            w_dp   = 1'b0;
            w_dm   = 1'b0;
            w_ones = '0;
        end else if (w_state == ST_EOP_J) begin
            w_dp = 1'b1;
            w_dm = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_ones     <= '0;
            r_dp       <= 1'b1;
            r_dm       <= 1'b0;
            r_pid      <= '0;
            r_is_data  <= 1'b0;
            r_len      <= '0;
            r_data     <= '0;
        end else begin
            r_state    <= w_state;
            r_timer    <= w_timer;
            r_bit_idx  <= w_bit_idx;
            r_byte_idx <= w_byte_idx;
            r_ones     <= w_ones;
            r_dp       <= w_dp;
            r_dm       <= w_dm;
            if (w_accept) begin
                r_pid     <= tx_pid;
                r_is_data <= is_data_pid(tx_pid);
                r_len     <= (tx_len > c_max_len) ? c_max_len : tx_len;
                r_data    <= tx_data;
            end
        end
    end

    assign tx_busy = (r_state != ST_IDLE);
    assign tx_done = (r_state == ST_EOP_J) && (r_timer == c_last_tick);
    assign d_plus  = r_dp;
    assign d_minus = r_dm;

endmodule

`default_nettype wire

// File: tb/tb_usb_tx_packetizer.sv
// ============================================================================
// Module      : tb_usb_tx_packetizer
// Description : Scoreboard bench decoding the D+/D- lines of two transmitters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_tx_packetizer;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [3:0]  pid_a = '0, pid_b = '0;
    logic [3:0]  len_a = '0, len_b = '0;
    logic [63:0] data_a = '0;
    logic [71:0] data_b = '0;
    wire         busy_a, done_a, dp_a, dm_a;
    wire         busy_b, done_b, dp_b, dm_b;

    always #5 clk = ~clk;

    usb_tx_packetizer #(.MAX_BYTES(8), .CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .rst(rst), .tx_start(start_a), .tx_pid(pid_a),
        .tx_len(len_a), .tx_data(data_a), .tx_busy(busy_a),
        .tx_done(done_a), .d_plus(dp_a), .d_minus(dm_a)
    );

    usb_tx_packetizer #(.MAX_BYTES(9), .CLKS_PER_BIT(CPB)) dut_b (
        .clk(clk), .rst(rst), .tx_start(start_b), .tx_pid(pid_b),
        .tx_len(len_b), .tx_data(data_b), .tx_busy(busy_b),
        .tx_done(done_b), .d_plus(dp_b), .d_minus(dm_b)
    );

    int checks = 0;
    int failures = 0;

    byte unsigned exp_q[$];
    int           nbits_q[$];
    int           cnt_q[$];

    logic [1:0]   line_s [0:2047];
    logic         done_s [0:2047];
    int           ncyc;
    byte unsigned dec_bytes [0:31];
    int           n_stuff, first_stuff;

    function automatic logic [3:0] smp(input int sel);
        return (sel != 0) ? {busy_b, done_b, dp_b, dm_b} : {busy_a, done_a, dp_a, dm_a};
    endfunction

    function automatic logic [15:0] crc_model(input logic [71:0] d, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < 8 * n; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Expected unstuffed byte stream plus frame length in bit periods.
    task automatic push_expected(input logic [3:0] pid, input logic [71:0] d, input int n);
        byte unsigned fr[$];
        logic [15:0]  c;
        int           ones = 0, stuffs = 0;
        fr.push_back(8'h80);
        fr.push_back({~pid, pid});
        if (pid == 4'h3 || pid == 4'hB) begin
            for (int i = 0; i < n; i++) fr.push_back(d[i*8 +: 8]);
            c = crc_model(d, n);
            fr.push_back(~c[7:0]);
            fr.push_back(~c[15:8]);
        end
        foreach (fr[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (fr[i][b]) ones++;
                else          ones = 0;
                if (ones == 6) begin
                    stuffs++;
                    ones = 0;
                end
            end
            exp_q.push_back(fr[i]);
        end
        nbits_q.push_back(fr.size() * 8 + stuffs + 3);
        cnt_q.push_back(fr.size());
    endtask

    task automatic send(input int sel, input logic [3:0] pid, input logic [3:0] len,
                        input logic [71:0] d);
        if (sel != 0) begin
            pid_b = pid; len_b = len; data_b = d; start_b = 1'b1;
        end else begin
            pid_a = pid; len_a = len; data_a = d[63:0]; start_a = 1'b1;
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic capture(input int sel, input int poke);
        logic [3:0] s;
        logic       ended = 1'b0;
        ncyc = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            s = smp(sel);
            if (!s[3]) begin
                ended = 1'b1;
                break;
            end
            line_s[ncyc] = s[1:0];
            done_s[ncyc] = s[2];
            ncyc++;
            if (poke >= 0 && t == poke) begin
                start_a = 1'b1; pid_a = 4'h2; len_a = 4'd1; data_a = ~data_a;
            end
            if (poke >= 0 && t == poke + 1) start_a = 1'b0;
        end
        checks++;
        if (!ended) begin
            failures++;
            $display("FAIL capture_timeout: busy still high after %0d cycles, want low", ncyc);
        end
    endtask

    task automatic decode(input string name);
        bit   bits[$];
        int   exp_bits, exp_cnt, viol = 0, dones = 0, se0 = 0, jend = 0;
        int   ones = 0, stuff_err = 0;
        logic [1:0] prev = 2'b10, s;
        byte unsigned e;
        exp_bits = nbits_q.pop_front();
        exp_cnt  = cnt_q.pop_front();
        n_stuff = 0;
        first_stuff = -1;

        checks++;
        if (ncyc !== exp_bits * CPB) begin
            failures++;
            $display("FAIL %s frame_len: got %0d cycles want %0d", name, ncyc, exp_bits * CPB);
        end
        for (int i = 0; i < ncyc; i++) begin
            if (line_s[i] !== line_s[i - (i % CPB)]) viol++;
            if (done_s[i]) dones++;
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL %s bit_hold: %0d mid-bit line changes, want 0", name, viol);
        end
        checks++;
        if (ncyc == 0 || dones != 1 || done_s[ncyc-1] !== 1'b1) begin
            failures++;
            $display("FAIL %s done_pulse: %0d pulses, want 1 in last busy cycle", name, dones);
        end

        for (int k = 0; k < ncyc / CPB; k++) begin
            s = line_s[k * CPB];
            if (s == 2'b00) begin
                se0++;
            end else if (se0 > 0) begin
                if (s == 2'b10) jend++;
            end else begin
                if (ones == 6) begin
                    if (s == prev) stuff_err++;
                    n_stuff++;
                    if (first_stuff < 0) first_stuff = k;
                    ones = 0;
                end else begin
                    bits.push_back(s == prev);
                    ones = (s == prev) ? ones + 1 : 0;
                end
                prev = s;
            end
        end
        checks++;
        if (se0 != 2 || jend != 1 || stuff_err != 0) begin
            failures++;
            $display("FAIL %s eop_stuff: se0=%0d j=%0d bad_stuff=%0d, want 2 1 0",
                     name, se0, jend, stuff_err);
        end

        checks++;
        if (bits.size() != exp_cnt * 8) begin
            failures++;
            $display("FAIL %s bit_count: got %0d data bits want %0d", name, bits.size(), exp_cnt * 8);
        end
        for (int i = 0; i < exp_cnt; i++) begin
            dec_bytes[i] = 8'h00;
            for (int b = 0; b < 8; b++)
                if (i * 8 + b < bits.size()) dec_bytes[i][b] = bits[i * 8 + b];
            e = exp_q.pop_front();
            checks++;
            if (dec_bytes[i] !== e) begin
                failures++;
                $display("FAIL %s byte%0d: got %02h want %02h", name, i, dec_bytes[i], e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({dp_a, dm_a, busy_a, done_a} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_a: dp,dm,busy,done=%b want 1000", {dp_a, dm_a, busy_a, done_a});
        end
        checks++;
        if ({dp_b, dm_b, busy_b, done_b} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_b: dp,dm,busy,done=%b want 1000", {dp_b, dm_b, busy_b, done_b});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ack();
        int se0c = 0;
        push_expected(4'h2, '0, 0);
        send(0, 4'h2, 4'd0, '0);
        capture(0, -1);
        decode("ack");
        for (int i = 0; i < ncyc; i++) if (line_s[i] == 2'b00) se0c++;
        checks++;
        if (ncyc != 19 * CPB || se0c != 8 || dec_bytes[1] !== 8'hD2) begin
            failures++;
            $display("FAIL ack_shape: busy=%0d se0=%0d pid=%02h want 76 8 d2", ncyc, se0c, dec_bytes[1]);
        end
    endtask

    task automatic test_data0_empty();
        push_expected(4'h3, '0, 0);
        send(0, 4'h3, 4'd0, '0);
        capture(0, -1);
        decode("data0_len0");
        checks++;
        if (dec_bytes[1] !== 8'hC3 || dec_bytes[2] !== 8'h00 || dec_bytes[3] !== 8'h00) begin
            failures++;
            $display("FAIL data0_len0_const: got %02h %02h %02h want c3 00 00",
                     dec_bytes[1], dec_bytes[2], dec_bytes[3]);
        end
    endtask

    task automatic test_crc_check();
        logic [71:0] d;
        for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'h31 + 8'(i);
        push_expected(4'hB, d, 9);
        send(1, 4'hB, 4'd9, d);
        capture(1, -1);
        decode("crc_check");
        checks++;
        if (dec_bytes[11] !== 8'hC8 || dec_bytes[12] !== 8'hB4) begin
            failures++;
            $display("FAIL crc_check_const: got %02h %02h want c8 b4", dec_bytes[11], dec_bytes[12]);
        end
    endtask

    task automatic test_stuff();
        push_expected(4'h3, 72'hFF, 1);
        send(0, 4'h3, 4'd1, 72'hFF);
        capture(0, -1);
        decode("stuff_ff");
        checks++;
        if (first_stuff != 20) begin
            failures++;
            $display("FAIL stuff_pos: first stuff at bit %0d want 20", first_stuff);
        end
    endtask

    task automatic test_ignore_start();
        logic [71:0] d = {8'h00, $urandom, $urandom};
        push_expected(4'h3, d, 2);
        send(0, 4'h3, 4'd2, d);
        capture(0, 30);
        decode("ignore_start");
    endtask

    task automatic test_reset_mid();
        int   dones = 0;
        logic was_busy;
        send(0, 4'h3, 4'd4, {8'h00, $urandom, $urandom});
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        was_busy = busy_a;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dp_a, dm_a, busy_a, done_a} !== 4'b1000 || !was_busy) begin
            failures++;
            $display("FAIL reset_mid: dp,dm,busy,done=%b was_busy=%b want 1000 1",
                     {dp_a, dm_a, busy_a, done_a}, was_busy);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        checks++;
        if (dones != 0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_done: %0d done pulses busy=%b want 0 0", dones, busy_a);
        end
    endtask

    task automatic test_clamp();
        logic [71:0] d = {8'hA5, $urandom, $urandom};
        push_expected(4'hB, d, 8);
        send(0, 4'hB, 4'd15, d);
        capture(0, -1);
        decode("clamp_len15");
    endtask

    task automatic test_back_to_back();
        push_expected(4'h2, '0, 0);
        send(0, 4'h2, 4'd0, '0);
        capture(0, -1);
        decode("b2b_ack");
        checks++;
        if ({dp_a, dm_a} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_idle: lines=%b want 10", {dp_a, dm_a});
        end
        push_expected(4'hA, '0, 0);
        send(0, 4'hA, 4'd0, '0);
        capture(0, -1);
        decode("b2b_nak");
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data0_empty();
        test_crc_check();
        test_stuff();
        test_ignore_start();
        test_reset_mid();
        test_clamp();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
